// File: rtl/tl_phase_controller_pkg.sv
// Shared lamp encodings, FSM state type and lamp-group helper for the
// tl_phase_controller intersection block.
package tl_pkg;

   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_GREEN  = 3'b010;
   localparam logic [2:0] LAMP_YELLOW = 3'b001;

   localparam int MAX_PHASES = 8;

   typedef enum logic [1:0] {
      ST_GREEN,
      ST_YELLOW,
      ST_ALLRED,
      ST_EMG_HOLD
   } tl_state_e;

   // Returns lamp group idx from a packed lights vector (zero-extended to MAX_PHASES groups).
   function automatic logic [2:0] lamp_of(input logic [3*MAX_PHASES-1:0] lights,
                                          input int unsigned idx);
      return lights[3*idx +: 3];
   endfunction

endpackage

// File: rtl/tl_phase_controller_timer.sv
// Loadable down-counter for interval timing; done is high while the count reads zero.
module tl_phase_timer #(
   parameter int                   TIMER_W = 8,
   parameter logic [TIMER_W-1:0]   RST_VAL = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic [TIMER_W-1:0] load_val_i,
   output logic               done_o
);

   logic [TIMER_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= RST_VAL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/tl_phase_controller.sv
// N-phase traffic-light controller with all-red clearance and emergency pre-emption.
// Pedestrian walk requests are built only when TL_PED_EN is defined.
module tl_phase_controller
   import tl_pkg::*;
#(
   parameter int NUM_PHASES = 4,
   parameter int GREEN_CYC  = 10,
   parameter int YELLOW_CYC = 3,
   parameter int ALLRED_CYC = 2,
   parameter int TIMER_W    = 8,
   localparam int PW        = $clog2(NUM_PHASES)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    emergency,
   input  logic [PW-1:0]           emg_phase,
   input  logic [NUM_PHASES-1:0]   ped_req,
   output logic [3*NUM_PHASES-1:0] lights,
   output logic [PW-1:0]           cur_phase,
   output logic                    emg_ack,
   output logic [NUM_PHASES-1:0]   walk
);

   localparam logic [TIMER_W-1:0] G_LD  = TIMER_W'(GREEN_CYC - 1);
   localparam logic [TIMER_W-1:0] Y_LD  = TIMER_W'(YELLOW_CYC - 1);
   localparam logic [TIMER_W-1:0] AR_LD = TIMER_W'(ALLRED_CYC - 1);
   localparam logic [PW-1:0]      LAST  = PW'(NUM_PHASES - 1);

   tl_state_e          state_q, state_d;
   logic [PW-1:0]      phase_q, phase_d;
   logic [PW-1:0]      tgt_q, tgt_d;
   logic               pend_q, pend_d;
   logic [PW-1:0]      emg_tgt;
   logic [PW-1:0]      phase_nxt;
   logic               tmr_load;
   logic [TIMER_W-1:0] tmr_val;
   logic               tmr_done;
   logic               green_entry;

   assign emg_tgt   = (32'(emg_phase) < NUM_PHASES) ? emg_phase : '0;
   assign phase_nxt = (phase_q == LAST) ? '0 : phase_q + PW'(1);

   tl_phase_timer #(
      .TIMER_W (TIMER_W),
      .RST_VAL (G_LD)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .done_o     (tmr_done)
   );

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      tgt_d       = tgt_q;
      pend_d      = pend_q;
      tmr_load    = 1'b0;
      tmr_val     = '0;
      green_entry = 1'b0;
      unique case (state_q)
         ST_GREEN: begin
            // Serving phase already the target: hold green without touching the timer.
            if (emergency && (phase_q == emg_tgt)) begin
               state_d = ST_EMG_HOLD;
            end else if (emergency || tmr_done) begin
               if (emergency) begin
                  tgt_d  = emg_tgt;
                  pend_d = 1'b1;
               end
               state_d  = ST_YELLOW;
               tmr_load = 1'b1;
               tmr_val  = Y_LD;
            end
         end
         ST_YELLOW, ST_ALLRED: begin
            if (emergency && !pend_q) begin
               tgt_d  = emg_tgt;
               pend_d = 1'b1;
            end
            if (tmr_done) begin
               if (state_q == ST_YELLOW) begin
                  state_d  = ST_ALLRED;
                  tmr_load = 1'b1;
                  tmr_val  = AR_LD;
               end else if (pend_d) begin
                  state_d = ST_EMG_HOLD;
                  phase_d = tgt_d;
                  pend_d  = 1'b0;
               end else begin
                  state_d     = ST_GREEN;
                  phase_d     = phase_nxt;
                  tmr_load    = 1'b1;
                  tmr_val     = G_LD;
                  green_entry = 1'b1;
               end
            end
         end
         ST_EMG_HOLD: begin
            if (!emergency) begin
               state_d  = ST_YELLOW;
               tmr_load = 1'b1;
               tmr_val  = Y_LD;
            end
         end
         default: state_d = ST_GREEN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_GREEN;
         phase_q <= '0;
         tgt_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         tgt_q   <= tgt_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_PHASES; i++) begin
         lights[3*i +: 3] = LAMP_RED;
         if (phase_q == PW'(i)) begin
            if (state_q == ST_GREEN || state_q == ST_EMG_HOLD) begin
               lights[3*i +: 3] = LAMP_GREEN;
            end else if (state_q == ST_YELLOW) begin
               lights[3*i +: 3] = LAMP_YELLOW;
            end
         end
      end
   end

   assign cur_phase = phase_q;
   assign emg_ack   = (state_q == ST_EMG_HOLD);

`ifdef TL_PED_EN
   logic [NUM_PHASES-1:0] plat_q, plat_d;
   logic [NUM_PHASES-1:0] walk_q, walk_d;

   // A request coinciding with the entry edge is served by that green.
   always_comb begin
      plat_d = plat_q | ped_req;
      walk_d = (state_d == ST_GREEN) ? walk_q : '0;
      if (green_entry) begin
         walk_d          = '0;
         walk_d[phase_d] = plat_d[phase_d];
         plat_d[phase_d] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         plat_q <= '0;
         walk_q <= '0;
      end else begin
         plat_q <= plat_d;
         walk_q <= walk_d;
      end
   end

   assign walk = walk_q;
`else
   logic unused_ped;
   assign unused_ped = ^{ped_req, green_entry};
   assign walk       = '0;
`endif

endmodule

// File: tb/tb_tl_phase_controller.sv
// Bench for tl_phase_controller (N=3, G=5, Y=2, AR=1): directed scenarios plus random traffic
// against an interval-level reference model.
module tb_tl_phase_controller;
   import tl_pkg::*;

   localparam int N  = 3;
   localparam int G  = 5;
   localparam int Y  = 2;
   localparam int AR = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       emergency = 1'b0;
   logic [1:0] emg_phase = '0;
   logic [2:0] ped_req = '0;
   logic [8:0] lights;
   logic [1:0] cur_phase;
   logic       emg_ack;
   logic [2:0] walk;

   int checks = 0;
   int errors = 0;

`ifdef TL_PED_EN
   localparam logic [2:0] W1 = 3'b010;
`else
   localparam logic [2:0] W1 = 3'b000;
`endif
   localparam logic [8:0] ALL_RED = 9'b100_100_100;
   localparam logic [8:0] RST_LTS = 9'b100_100_010;

   always #5 clk = ~clk;

   tl_phase_controller #(
      .NUM_PHASES (N),
      .GREEN_CYC  (G),
      .YELLOW_CYC (Y),
      .ALLRED_CYC (AR),
      .TIMER_W    (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .emergency (emergency),
      .emg_phase (emg_phase),
      .ped_req   (ped_req),
      .lights    (lights),
      .cur_phase (cur_phase),
      .emg_ack   (emg_ack),
      .walk      (walk)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: interval kind, owning phase and cycles left in the interval.
   // kind: 0 green, 1 yellow, 2 all-red, 3 emergency hold
   int       m_kind, m_phase, m_left, m_tgt;
   bit       m_pend;
   bit [2:0] m_plat, m_walk;

   function automatic void model_reset();
      m_kind = 0; m_phase = 0; m_left = G; m_tgt = 0;
      m_pend = 0; m_plat = '0; m_walk = '0;
   endfunction

   function automatic void model_step(input bit e, input int ep, input bit [2:0] pr);
      int t;
      bit entry;
      t = (ep < N) ? ep : 0;
      entry = 0;
      case (m_kind)
         0: begin
            if (e && m_phase == t) m_kind = 3;
            else if (e || m_left == 1) begin
               if (e) begin m_tgt = t; m_pend = 1; end
               m_kind = 1; m_left = Y;
            end else m_left--;
         end
         1, 2: begin
            if (e && !m_pend) begin m_pend = 1; m_tgt = t; end
            if (m_left > 1) m_left--;
            else if (m_kind == 1) begin m_kind = 2; m_left = AR; end
            else if (m_pend) begin m_kind = 3; m_phase = m_tgt; m_pend = 0; end
            else begin m_kind = 0; m_phase = (m_phase + 1) % N; m_left = G; entry = 1; end
         end
         default: if (!e) begin m_kind = 1; m_left = Y; end
      endcase
      m_plat |= pr;
      if (entry) begin
         m_walk = '0;
         m_walk[m_phase] = m_plat[m_phase];
         m_plat[m_phase] = 1'b0;
      end else if (m_kind != 0) m_walk = '0;
   endfunction

   function automatic logic [8:0] exp_lights();
      logic [8:0] v;
      for (int i = 0; i < N; i++) begin
         v[3*i +: 3] = LAMP_RED;
         if (i == m_phase && (m_kind == 0 || m_kind == 3)) v[3*i +: 3] = LAMP_GREEN;
         if (i == m_phase && m_kind == 1) v[3*i +: 3] = LAMP_YELLOW;
      end
      return v;
   endfunction

   task automatic check_model();
`ifdef TL_PED_EN
      check_val("walk", 32'(walk), 32'(m_walk));
`else
      check_val("walk", 32'(walk), 32'(0));
`endif
      check_val("lights", 32'(lights), 32'(exp_lights()));
      check_val("cur_phase", 32'(cur_phase), 32'(m_phase));
      check_val("emg_ack", 32'(emg_ack), 32'(m_kind == 3));
   endtask

   task automatic cyc(input logic e, input logic [1:0] ep, input logic [2:0] pr);
      emergency = e; emg_phase = ep; ped_req = pr;
      @(negedge clk);
      check_model();
      @(posedge clk);
      model_step(e, int'(ep), pr);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; emergency = 1'b0; emg_phase = '0; ped_req = '0;
      @(posedge clk);
      #1;
      check_val("rst_lights", 32'(lights), 32'(RST_LTS));
      check_val("rst_ack", 32'(emg_ack), 32'(0));
      model_reset();
      rst_n = 1'b1;
   endtask

   initial begin
      logic emg_lvl;
      model_reset();

      // Idle sequence from reset
      do_reset();
      check_val("t1_c0_cur", 32'(cur_phase), 32'(0));
      check_val("t1_c0_walk", 32'(walk), 32'(0));
      for (int c = 0; c < 25; c++) begin
         cyc(1'b0, 2'd0, 3'b000);
         if (c + 1 == 5) check_val("t1_c5_lamp0", 32'(lamp_of(24'(lights), 0)), 32'(LAMP_YELLOW));
         if (c + 1 == 7) check_val("t1_c7_allred", 32'(lights), 32'(ALL_RED));
         if (c + 1 == 8) check_val("t1_c8_lamp1", 32'(lamp_of(24'(lights), 1)), 32'(LAMP_GREEN));
         if (c + 1 == 24) check_val("t1_c24_cur", 32'(cur_phase), 32'(0));
      end

      // Pre-emption of a non-target green
      do_reset();
      for (int c = 0; c < 16; c++) begin
         cyc(c >= 2 && c <= 9, 2'd2, 3'b000);
         if (c + 1 == 3) check_val("t2_c3_lamp0", 32'(lamp_of(24'(lights), 0)), 32'(LAMP_YELLOW));
         if (c + 1 == 5) check_val("t2_c5_allred", 32'(lights), 32'(ALL_RED));
         if (c + 1 == 6) check_val("t2_c6_ack", 32'(emg_ack), 32'(1));
         if (c + 1 == 6) check_val("t2_c6_lamp2", 32'(lamp_of(24'(lights), 2)), 32'(LAMP_GREEN));
         if (c + 1 == 11) check_val("t2_c11_lamp2", 32'(lamp_of(24'(lights), 2)), 32'(LAMP_YELLOW));
         if (c + 1 == 13) check_val("t2_c13_allred", 32'(lights), 32'(ALL_RED));
         if (c + 1 == 14) check_val("t2_c14_lamp0", 32'(lamp_of(24'(lights), 0)), 32'(LAMP_GREEN));
      end

      // Pre-emption of the green already serving the target
      do_reset();
      for (int c = 0; c < 11; c++) begin
         cyc(c >= 1 && c <= 7, 2'd0, 3'b000);
         if (c + 1 == 2) check_val("t3_c2_ack", 32'(emg_ack), 32'(1));
         if (c + 1 == 7) check_val("t3_c7_lamp0", 32'(lamp_of(24'(lights), 0)), 32'(LAMP_GREEN));
         if (c + 1 == 9) check_val("t3_c9_lamp0", 32'(lamp_of(24'(lights), 0)), 32'(LAMP_YELLOW));
      end

      // One-cycle emergency pulse during all-red
      do_reset();
      for (int c = 0; c < 14; c++) begin
         cyc(c == 7, 2'd2, 3'b000);
         if (c + 1 == 8) check_val("t4_c8_ack", 32'(emg_ack), 32'(1));
         if (c + 1 == 9) check_val("t4_c9_lamp2", 32'(lamp_of(24'(lights), 2)), 32'(LAMP_YELLOW));
         if (c + 1 == 11) check_val("t4_c11_allred", 32'(lights), 32'(ALL_RED));
         if (c + 1 == 12) check_val("t4_c12_lamp0", 32'(lamp_of(24'(lights), 0)), 32'(LAMP_GREEN));
      end

      // Pedestrian requests on phase 1
      do_reset();
      for (int c = 0; c < 38; c++) begin
         cyc(1'b0, 2'd0, (c == 3 || c == 10) ? 3'b010 : 3'b000);
         if (c + 1 == 8 || c + 1 == 12 || c + 1 == 32 || c + 1 == 36)
            check_val($sformatf("t5_walk_c%0d", c + 1), 32'(walk), 32'(W1));
         if (c + 1 == 13 || c + 1 == 24 || c + 1 == 37)
            check_val($sformatf("t5_walk_c%0d", c + 1), 32'(walk), 32'(0));
      end

      // Asynchronous reset in the middle of an emergency hold
      do_reset();
      for (int c = 0; c < 3; c++) cyc(1'b1, 2'd0, 3'b000);
      check_val("t6_hold_ack", 32'(emg_ack), 32'(1));
      #3 rst_n = 1'b0;
      #1;
      check_val("t6_async_lights", 32'(lights), 32'(RST_LTS));
      check_val("t6_async_ack", 32'(emg_ack), 32'(0));
      check_val("t6_async_cur", 32'(cur_phase), 32'(0));
      check_val("t6_async_walk", 32'(walk), 32'(0));
      model_reset();
      emergency = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Random traffic
      emg_lvl = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 11) == 0) emg_lvl = ~emg_lvl;
         cyc(emg_lvl, 2'($urandom_range(0, 3)),
             ($urandom_range(0, 6) == 0) ? 3'($urandom) : 3'b000);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
